// File: rtl/ddr_tx_gearbox.sv
// ddr_tx_gearbox: buffers full-width words in a small FIFO and emits them
// as two half-words on consecutive clocks for a dual-edge output register.
// data_o/en_o come straight from flops; data_ready_o depends only on the
// registered count and rst_i.
module ddr_tx_gearbox #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [2*WIDTH-1:0]         data_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  output logic [WIDTH-1:0]           data_o,
  output logic                       en_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE, SECOND} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   word_q, word_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 en_q, en_d;
  logic [2*WIDTH-1:0]   mem_q [DEPTH];
  logic                 push, pop;

  // Half selection follows the configured emission order.
  function automatic logic [WIDTH-1:0] first_half(input logic [2*WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[WIDTH-1:0] : w[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] second_half(input logic [2*WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[2*WIDTH-1:WIDTH] : w[WIDTH-1:0];
  endfunction

  // Ready is held low during reset and while full, even if a pop is due.
  assign data_ready_o = !rst_i && (count_q != FULL_CNT);
  assign data_o       = data_q;
  assign en_o         = en_q;
  assign count_o      = count_q;

  // Handshake, pop decision, output FSM and FIFO bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    word_d   = word_q;
    data_d   = data_q;
    en_d     = 1'b0;

    push = data_valid_i && data_ready_o;
    pop  = (state_q == IDLE) && (count_q != '0);

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          word_d   = mem_q[rd_ptr_q];
          data_d   = first_half(mem_q[rd_ptr_q]);
          en_d     = 1'b1;
          rd_ptr_d = rd_ptr_q + PW'(1);
          state_d  = SECOND;
        end
      end
      SECOND: begin
        data_d  = second_half(word_q);
        en_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      word_q   <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      word_q   <= word_d;
      data_q   <= data_d;
      en_q     <= en_d;
    end
  end

  // FIFO storage written on each accepted word.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; count_q gates every read, so stale entries
    // are never observed and the array can map onto plain RAM/regfile cells.
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_ddr_tx_gearbox.sv
// Self-checking bench for ddr_tx_gearbox. Two instances (LSB-first and
// MSB-first) share all inputs; a queue-based reference model predicts
// outputs from the handshake and emission rules.
module tb_ddr_tx_gearbox;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] din = '0;

  logic        rdy_l, en_l, rdy_m, en_m;
  logic [7:0]  do_l, do_m;
  logic [2:0]  cnt_l, cnt_m;

  int n_pass  = 0;
  int n_total = 0;

  ddr_tx_gearbox #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LSB_FIRST(1)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(din), .data_valid_i(valid),
    .data_ready_o(rdy_l), .data_o(do_l), .en_o(en_l), .count_o(cnt_l)
  );

  ddr_tx_gearbox #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LSB_FIRST(0)) dut_msb (
    .clk_i(clk), .rst_i(rst), .data_i(din), .data_valid_i(valid),
    .data_ready_o(rdy_m), .data_o(do_m), .en_o(en_m), .count_o(cnt_m)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of whole words plus one pending word whose
  // second half is still owed to the output.
  logic [15:0] mq[$];
  logic        m_pend = 1'b0;
  logic [15:0] m_word = '0;
  logic [7:0]  m_dl = '0, m_dm = '0;
  logic        m_en = 1'b0;

  function automatic logic m_rdy();
    return !rst && (mq.size() != DEPTH);
  endfunction

  initial begin
    logic do_push;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_pend = 1'b0; m_word = '0; m_dl = '0; m_dm = '0; m_en = 1'b0;
      end else begin
        do_push = valid && (mq.size() != DEPTH);
        if (m_pend) begin
          m_dl = m_word[15:8]; m_dm = m_word[7:0]; m_en = 1'b1; m_pend = 1'b0;
        end else if (mq.size() != 0) begin
          m_word = mq.pop_front();
          m_dl = m_word[7:0]; m_dm = m_word[15:8]; m_en = 1'b1; m_pend = 1'b1;
        end else begin
          m_en = 1'b0;
        end
        if (do_push) mq.push_back(din);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; din = 16'($urandom);
    #1;
    n_total++;
    if ({rdy_l, rdy_m} !== 2'b00)
      $display("FAIL reset_ready_pre got %b%b req 00", rdy_l, rdy_m);
    else n_pass++;
    tick();
    din = 16'($urandom);
    n_total++;
    if ({rdy_l, cnt_l, en_l} !== {1'b0, 3'd0, 1'b0})
      $display("FAIL reset_hold got rdy=%b cnt=%0d en=%b req 0/0/0", rdy_l, cnt_l, en_l);
    else n_pass++;
    tick();
    rst = 1'b0; valid = 1'b0;
    #1;
    n_total++;
    if ({do_l, en_l, cnt_l, rdy_l, do_m, en_m} !== {8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0})
      $display("FAIL reset_release got data=%h en=%b cnt=%0d rdy=%b msb=%h/%b req 00/0/0/1 00/0",
               do_l, en_l, cnt_l, rdy_l, do_m, en_m);
    else n_pass++;
  endtask

  // Covers LSB-first and MSB-first ordering with the same stimulus.
  task automatic test_single_word();
    valid = 1'b1; din = 16'hA55A;
    tick();
    valid = 1'b0;
    n_total++;
    if ({cnt_l, en_l} !== {3'd1, 1'b0})
      $display("FAIL single_e1 got cnt=%0d en=%b req 1/0", cnt_l, en_l);
    else n_pass++;
    tick();
    n_total++;
    if ({do_l, en_l, do_m, en_m} !== {8'h5A, 1'b1, 8'hA5, 1'b1})
      $display("FAIL single_e2 got lsb=%h/%b msb=%h/%b req 5a/1 a5/1", do_l, en_l, do_m, en_m);
    else n_pass++;
    tick();
    n_total++;
    if ({do_l, en_l, do_m, en_m} !== {8'hA5, 1'b1, 8'h5A, 1'b1})
      $display("FAIL single_e3 got lsb=%h/%b msb=%h/%b req a5/1 5a/1", do_l, en_l, do_m, en_m);
    else n_pass++;
    tick();
    n_total++;
    if ({do_l, en_l, cnt_l, do_m, en_m} !== {8'hA5, 1'b0, 3'd0, 8'h5A, 1'b0})
      $display("FAIL single_e4 got lsb=%h/%b cnt=%0d msb=%h/%b req a5/0/0 5a/0",
               do_l, en_l, cnt_l, do_m, en_m);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3] = '{16'h1122, 16'h3344, 16'h5566};
    logic [7:0]  got[$];
    logic [7:0]  exp[$];
    int          first_en = -1, last_en = -1, max_cnt = 0;
    foreach (words[k]) begin
      exp.push_back(words[k][7:0]);
      exp.push_back(words[k][15:8]);
    end
    for (int i = 0; i < 10; i++) begin
      valid = (i < 3);
      din   = (i < 3) ? words[i] : 16'h0;
      tick();
      if (en_l) begin
        got.push_back(do_l);
        if (first_en < 0) first_en = i;
        last_en = i;
      end
      if (int'(cnt_l) > max_cnt) max_cnt = int'(cnt_l);
      n_total++;
      if ({do_l, en_l, cnt_l, rdy_l, do_m, en_m} !== {m_dl, m_en, 3'(mq.size()), m_rdy(), m_dm, m_en})
        $display("FAIL b2b_model cyc=%0d got %h/%b/%0d/%b %h/%b req %h/%b/%0d/%b %h/%b", i,
                 do_l, en_l, cnt_l, rdy_l, do_m, en_m, m_dl, m_en, mq.size(), m_rdy(), m_dm, m_en);
      else n_pass++;
    end
    valid = 1'b0;
    n_total++;
    if (got.size() != 6 || (last_en - first_en) != 5)
      $display("FAIL b2b_run got %0d halves over span %0d req 6 over 5", got.size(), last_en - first_en);
    else n_pass++;
    for (int j = 0; j < 6 && j < got.size(); j++) begin
      n_total++;
      if (got[j] !== exp[j]) $display("FAIL b2b_seq idx=%0d got %h req %h", j, got[j], exp[j]);
      else n_pass++;
    end
    n_total++;
    if (max_cnt != 2) $display("FAIL b2b_peak got %0d req 2", max_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [15:0] nxt = 16'h0100;
    logic [7:0]  exp[$];
    logic [7:0]  got[$];
    int          max_cnt = 0;
    logic        saw_full_block = 1'b0;
    logic        accept;
    for (int i = 0; i < 26; i++) begin
      valid  = (i < 12);
      din    = nxt;
      accept = valid && m_rdy();
      tick();
      if (accept) begin
        exp.push_back(nxt[7:0]);
        exp.push_back(nxt[15:8]);
        nxt = nxt + 16'h0202;
      end
      if (en_l) got.push_back(do_l);
      if (int'(cnt_l) > max_cnt) max_cnt = int'(cnt_l);
      if (cnt_l == 3'd4 && !rdy_l) saw_full_block = 1'b1;
      n_total++;
      if ({do_l, en_l, cnt_l, rdy_l, do_m, en_m} !== {m_dl, m_en, 3'(mq.size()), m_rdy(), m_dm, m_en})
        $display("FAIL bp_model cyc=%0d got %h/%b/%0d/%b %h/%b req %h/%b/%0d/%b %h/%b", i,
                 do_l, en_l, cnt_l, rdy_l, do_m, en_m, m_dl, m_en, mq.size(), m_rdy(), m_dm, m_en);
      else n_pass++;
    end
    valid = 1'b0;
    n_total++;
    if (max_cnt != 4 || !saw_full_block)
      $display("FAIL bp_full got peak=%0d blocked=%b req 4/1", max_cnt, saw_full_block);
    else n_pass++;
    n_total++;
    if (got.size() != exp.size())
      $display("FAIL bp_len got %0d halves req %0d", got.size(), exp.size());
    else n_pass++;
    for (int j = 0; j < exp.size() && j < got.size(); j++) begin
      n_total++;
      if (got[j] !== exp[j]) $display("FAIL bp_seq idx=%0d got %h req %h", j, got[j], exp[j]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_word();
    int stray = 0;
    valid = 1'b1; din = 16'hA55A;
    tick();
    din = 16'h1234;
    tick();
    valid = 1'b0;
    n_total++;
    if ({do_l, en_l} !== {8'h5A, 1'b1})
      $display("FAIL midrst_first got %h/%b req 5a/1", do_l, en_l);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (rdy_l !== 1'b0) $display("FAIL midrst_ready got %b req 0", rdy_l);
    else n_pass++;
    tick();
    n_total++;
    if ({do_l, en_l, cnt_l, do_m, en_m} !== {8'h00, 1'b0, 3'd0, 8'h00, 1'b0})
      $display("FAIL midrst_edge got %h/%b/%0d msb %h/%b req 00/0/0 00/0", do_l, en_l, cnt_l, do_m, en_m);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (en_l || en_m) stray++;
    end
    n_total++;
    if (stray != 0) $display("FAIL midrst_stray got %0d emitting cycles req 0", stray);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      valid = ($urandom_range(0, 3) != 0);
      din   = 16'($urandom);
      tick();
      n_total++;
      if ({do_l, en_l, cnt_l, rdy_l, do_m, en_m} !== {m_dl, m_en, 3'(mq.size()), m_rdy(), m_dm, m_en})
        $display("FAIL rand_model cyc=%0d got %h/%b/%0d/%b %h/%b req %h/%b/%0d/%b %h/%b", i,
                 do_l, en_l, cnt_l, rdy_l, do_m, en_m, m_dl, m_en, mq.size(), m_rdy(), m_dm, m_en);
      else n_pass++;
    end
    rst = 1'b0; valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ddr_tx_gearbox.md
# ddr_tx_gearbox

Single-clock gearbox that feeds the team's dual-edge output register. It accepts full-width words (2×WIDTH bits) on a valid/ready handshake and buffers them in a small FIFO. It splits each word into two WIDTH-bit halves and presents them one per clock on `data_o`, qualified by `en_o`. `data_o`/`en_o` connect directly to the dual-edge register's `data_i`/`en_i`. Both outputs are registered, so downstream sees glitch-free, edge-aligned data.

## Interface
- `WIDTH`, 8: width of one half-word and of `data_o`; ≥1.
- `DEPTH`, 4: FIFO depth in full words; power of two, ≥2.
- `LSB_FIRST`, 1: 1 = emit `data_i[WIDTH-1:0]` first; 0 = emit `data_i[2*WIDTH-1:WIDTH]` first.

Ports:
- `clk_i` in 1: clock. One clock domain; all state updates on the rising edge.
- `rst_i` in 1: reset. Synchronous, active-high.
- `data_i` in 2*WIDTH: input word.
- `data_valid_i` in 1: `data_i` valid.
- `data_ready_o` out 1: FIFO can accept a word this cycle.
- `data_o` out WIDTH: half-word to the dual-edge register.
- `en_o` out 1: `data_o` carries a new half this cycle.
- `count_o` out $clog2(DEPTH+1): words currently held in the FIFO. Excludes a word whose first half has already been emitted.

## Operation
**Push side**
- A push occurs when `data_valid_i && data_ready_o` at a rising edge.
- `data_ready_o = !rst_i && (count_o != DEPTH)`. It is combinational from registered count and `rst_i`.
- When full, `data_ready_o` is 0 even if a pop happens in the same cycle. There is no full-pass-through.
- There is no bypass. A word pushed at edge N is poppable at edge N+1 at the earliest.

**Output FSM** (two states, plus `word_q` holding the popped word)
- IDLE, FIFO empty at edge:
  - `en_o` <= 0; `data_o` holds its previous value.
  - Stay IDLE.
- IDLE, FIFO non-empty at edge:
  - Pop the head into `word_q`.
  - `data_o` <= first half of the head; `en_o` <= 1.
  - Go to SECOND.
- SECOND at edge:
  - `data_o` <= second half of `word_q`; `en_o` <= 1.
  - No pop in this cycle. Go to IDLE.
- First/second half is selected per `LSB_FIRST`.
- Throughput: one word per 2 cycles. With the FIFO non-empty, `en_o` stays continuously 1.

**Count**
- `count_o` is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- It never exceeds DEPTH and never underflows.

**Reset** (`rst_i` high at an edge)
- FIFO is emptied: pointers 0, `count_o` = 0.
- State = IDLE, `word_q` = 0, `data_o` = 0, `en_o` = 0.
- A pending second half is discarded.
- `data_ready_o` = 0 while `rst_i` is high and 1 in the first cycle after release.
- `data_valid_i` is ignored during reset.

## Timing
- Latency: word accepted at edge N into an empty FIFO with the FSM in IDLE:
  - first half on `data_o` after edge N+1,
  - second half after edge N+2,
  - `en_o` = 0 after edge N+3 if nothing follows.
- A word waiting in the FIFO while the FSM is in SECOND is popped at the edge after that second half. No bubble between words.
- Outputs come straight from flops. There is no combinational path from `data_i` or `data_valid_i` to `data_o`/`en_o`.
- `data_ready_o` does not depend on `data_valid_i`.

## Test plan
Settings: WIDTH=8, DEPTH=4, LSB_FIRST=1 unless stated.

1. **Reset:** hold `rst_i`=1 for 2 edges with `data_valid_i`=1.
   - During reset: `data_ready_o`=0, no push.
   - After release: `data_o`=0x00, `en_o`=0, `count_o`=0, `data_ready_o`=1.
2. **Single word:** push 0xA55A at edge 1.
   - After edge 2: `data_o`=0x5A, `en_o`=1.
   - After edge 3: 0xA5, `en_o`=1.
   - After edge 4: `en_o`=0, `data_o` stays 0xA5, `count_o`=0.
3. **Back-to-back:** push 0x1122, 0x3344, 0x5566 on consecutive edges.
   - Output sequence: 0x22, 0x11, 0x44, 0x33, 0x66, 0x55, with `en_o`=1 for exactly 6 consecutive cycles and no gaps.
   - `count_o` peaks at 2.
4. **Full/backpressure:** hold `data_valid_i`=1 with an incrementing pattern 0x0100, 0x0302, … for 12 edges.
   - `count_o` reaches 4 and `data_ready_o` drops to 0 while full.
   - Only handshaked words appear, in order, with no duplicates or drops.
   - `count_o` never exceeds 4.
5. **Ordering:** rerun scenario 2 with LSB_FIRST=0. 0xA55A emits 0xA5 then 0x5A.
6. **Reset mid-word:** push 0xA55A and 0x1234.
   - Assert `rst_i` in the cycle right after 0x5A is emitted.
   - At that edge: `data_o`=0x00, `en_o`=0, `count_o`=0.
   - 0xA5, 0x34 and 0x12 are never emitted.
